edac_err_monitor: RTL and testbench
===================================

// Module: edac_err_monitor
// PURPOSE
//  Error-logging stage placed directly downstream of the CoreEDAC TMR wrapper. It consumes the
//  voted decoder flags (correctable, error), the scrub flags (scrub_done, scrub_corr) and
//  ram_rA_lat, and turns them into outputs software can read:
//  - saturating error counters
//  - captured error addresses
//  - a health state machine
//  - a level interrupt
// PARAMETERS
//  RAM_LOGDEPTH  8   width of ram_rA_lat and of the captured addresses
//  CNT_WIDTH     16  width of every event counter; counters saturate at 2^CNT_WIDTH-1
// PORTS
//  rClk          in   1             single clock; all logic is on rising edge
//  nGrst         in   1             asynchronous, active-low reset
//  dec_valid     in   1             qualifies correctable/error/ram_rA_lat for this cycle
//  correctable   in   1             single-bit error detected and corrected (voted)
//  error         in   1             uncorrectable (double-bit) error detected (voted)
//  ram_rA_lat    in   RAM_LOGDEPTH  address aligned with the decoder flags
//  scrub_done    in   1             level/pulse; a rising edge marks the end of a scrub pass
//  scrub_corr    in   1             scrub pass wrote back a corrected word (sampled every cycle)
//  sec_thresh    in   CNT_WIDTH     SEC count at which WARN is entered; 0 disables WARN
//  clr_cnt       in   1             1-cycle pulse: clear all counters
//  clr_fault     in   1             1-cycle pulse: return health to NORMAL, re-arm DED capture
//  irq_ack       in   1             1-cycle pulse: clear irq
//  sec_cnt       out  CNT_WIDTH     count of qualified correctable events
//  ded_cnt       out  CNT_WIDTH     count of qualified uncorrectable events
//  scrub_cnt     out  CNT_WIDTH     count of completed scrub passes
//  scrubfix_cnt  out  CNT_WIDTH     count of cycles with scrub_corr=1
//  sec_addr      out  RAM_LOGDEPTH  address of the most recent SEC event
//  ded_addr      out  RAM_LOGDEPTH  address of the first DED since the last clr_fault
//  health        out  2             00 NORMAL, 01 WARN, 10 FAULT
//  irq           out  1             level interrupt
// BEHAVIOUR
//  Reset: all counters, sec_addr, ded_addr and irq are 0; health is NORMAL; scrub_done edge
//   register is 0. Reset mid-operation discards all state immediately (asynchronous).
//  Event decode is registered; outputs update 1 cycle after the qualifying input cycle.
//  Events:
//   - DED event: dec_valid & error.
//   - SEC event: dec_valid & correctable & ~error (error wins when both flags are set).
//   - Flags are ignored when dec_valid=0.
//  Counters: +1 per event, saturate at all-ones and never wrap.
//   - clr_cnt in the same cycle as an event: the counter ends at 1.
//   - scrub_cnt increments on a scrub_done rising edge only (0->1 between consecutive cycles).
//  Address capture:
//   - sec_addr loads ram_rA_lat on every SEC event.
//   - ded_addr loads only on the first DED after reset or clr_fault; later DEDs leave it held.
//   - clr_fault in the same cycle as a DED: the DED address is captured.
//  Health FSM (evaluated on the post-update counter values):
//   - NORMAL -> FAULT on a DED event.
//   - NORMAL -> WARN when sec_thresh!=0 and sec_cnt>=sec_thresh.
//   - WARN -> FAULT on a DED event; WARN -> NORMAL on clr_cnt or clr_fault.
//   - FAULT is sticky; it leaves only on clr_fault, going to NORMAL (or to FAULT again if a
//     DED occurs in the same cycle).
//   - State 11 is illegal and recovers to FAULT.
//  irq:
//   - set on any DED event, and on the NORMAL->WARN transition;
//   - cleared by irq_ack; when set and irq_ack coincide, set wins (irq stays 1).
// TESTING
//  1 Reset, 3 SEC events at addrs 0x10,0x20,0x30 -> sec_cnt=3, sec_addr=0x30, health=00, irq=0.
//  2 sec_thresh=2, 2 SEC events -> health=01 and irq=1 one cycle after the 2nd; irq_ack -> irq=0.
//  3 DED at 0x55, then DED at 0x66 -> ded_cnt=2, ded_addr=0x55, health=10;
//    clr_fault -> health=00; next DED at 0x77 -> ded_addr=0x77.
//  4 correctable=error=1 with dec_valid=1 -> ded_cnt+1, sec_cnt unchanged;
//    same flags with dec_valid=0 -> no change.
//  5 CNT_WIDTH=4, 20 SEC events -> sec_cnt=15; clr_cnt together with a SEC event -> sec_cnt=1.
//  6 scrub_done held high 5 cycles, twice -> scrub_cnt=2; nGrst low mid-run -> all outputs 0.

Source files
------------

// File: rtl/edac_err_monitor_if.sv
// rtl/edac_err_monitor_if.sv - voted decoder flag bundle from the EDAC TMR wrapper
interface edac_err_monitor_if #(
   parameter int RAM_LOGDEPTH = 8
);
   logic                    dec_valid;
   logic                    correctable;
   logic                    error;
   logic [RAM_LOGDEPTH-1:0] ram_rA_lat;

   modport master (output dec_valid, correctable, error, ram_rA_lat);
   modport slave  (input  dec_valid, correctable, error, ram_rA_lat);
endinterface

// File: rtl/edac_err_monitor.sv
// rtl/edac_err_monitor.sv - EDAC error logger: saturating counters, address capture, health FSM, irq
// All state updates on the edge that samples the qualifying input cycle.
module edac_err_monitor #(
   parameter int RAM_LOGDEPTH = 8,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    rClk,
   input  logic                    nGrst,
   edac_err_monitor_if.slave       dec,
   input  logic                    scrub_done,
   input  logic                    scrub_corr,
   input  logic [CNT_WIDTH-1:0]    sec_thresh,
   input  logic                    clr_cnt,
   input  logic                    clr_fault,
   input  logic                    irq_ack,
   output logic [CNT_WIDTH-1:0]    sec_cnt,
   output logic [CNT_WIDTH-1:0]    ded_cnt,
   output logic [CNT_WIDTH-1:0]    scrub_cnt,
   output logic [CNT_WIDTH-1:0]    scrubfix_cnt,
   output logic [RAM_LOGDEPTH-1:0] sec_addr,
   output logic [RAM_LOGDEPTH-1:0] ded_addr,
   output logic [1:0]              health,
   output logic                    irq
);

   typedef enum logic [1:0] {
      H_NORMAL  = 2'b00,
      H_WARN    = 2'b01,
      H_FAULT   = 2'b10,
      H_ILLEGAL = 2'b11
   } health_t;

   health_t state_q, state_d;

   logic                 sec_ev, ded_ev, scrub_rise;
   logic                 scrub_q;
   logic                 ded_captured;
   logic                 irq_set;
   logic [CNT_WIDTH-1:0] sec_cnt_d, ded_cnt_d, scrub_cnt_d, scrubfix_cnt_d;

   // A clear coinciding with an event leaves the counter at 1, not 0.
   function automatic logic [CNT_WIDTH-1:0] cnt_next(
      input logic [CNT_WIDTH-1:0] cnt,
      input logic                 ev,
      input logic                 clr
   );
      if (clr)
         return ev ? CNT_WIDTH'(1) : '0;
      else if (ev && !(&cnt))
         return cnt + CNT_WIDTH'(1);
      else
         return cnt;
   endfunction

   assign ded_ev     = dec.dec_valid & dec.error;
   assign sec_ev     = dec.dec_valid & dec.correctable & ~dec.error;
   assign scrub_rise = scrub_done & ~scrub_q;

   always_comb begin
      sec_cnt_d      = cnt_next(sec_cnt, sec_ev, clr_cnt);
      ded_cnt_d      = cnt_next(ded_cnt, ded_ev, clr_cnt);
      scrub_cnt_d    = cnt_next(scrub_cnt, scrub_rise, clr_cnt);
      scrubfix_cnt_d = cnt_next(scrubfix_cnt, scrub_corr, clr_cnt);
   end

   // Health decisions look at the counter values this edge will store.
   always_comb begin
      state_d = state_q;
      irq_set = ded_ev;
      case (state_q)
         H_NORMAL: begin
            if (ded_ev)
               state_d = H_FAULT;
            else if ((sec_thresh != '0) && (sec_cnt_d >= sec_thresh)) begin
               state_d = H_WARN;
               irq_set = 1'b1;
            end
         end
         H_WARN: begin
            if (ded_ev)
               state_d = H_FAULT;
            else if (clr_cnt || clr_fault)
               state_d = H_NORMAL;
         end
         H_FAULT: begin
            if (clr_fault)
               state_d = ded_ev ? H_FAULT : H_NORMAL;
         end
         default: state_d = H_FAULT;
      endcase
   end

   always_ff @(posedge rClk or negedge nGrst) begin
      if (!nGrst) begin
         state_q      <= H_NORMAL;
         scrub_q      <= 1'b0;
         sec_cnt      <= '0;
         ded_cnt      <= '0;
         scrub_cnt    <= '0;
         scrubfix_cnt <= '0;
         sec_addr     <= '0;
         ded_addr     <= '0;
         ded_captured <= 1'b0;
         irq          <= 1'b0;
      end else begin
         state_q      <= state_d;
         scrub_q      <= scrub_done;
         sec_cnt      <= sec_cnt_d;
         ded_cnt      <= ded_cnt_d;
         scrub_cnt    <= scrub_cnt_d;
         scrubfix_cnt <= scrubfix_cnt_d;
         if (sec_ev)
            sec_addr <= dec.ram_rA_lat;
         // clr_fault re-arms capture in the same cycle, so a coincident DED is logged.
         if (ded_ev && (!ded_captured || clr_fault)) begin
            ded_addr     <= dec.ram_rA_lat;
            ded_captured <= 1'b1;
         end else if (clr_fault) begin
            ded_captured <= 1'b0;
         end
         if (irq_set)
            irq <= 1'b1;
         else if (irq_ack)
            irq <= 1'b0;
      end
   end

   assign health = state_q;

endmodule

// File: tb/tb_edac_err_monitor.sv
// tb/tb_edac_err_monitor.sv - directed table-driven bench for edac_err_monitor
module tb_edac_err_monitor;

   logic        rClk = 1'b0;
   logic        nGrst = 1'b0;
   logic        scrub_done = 1'b0, scrub_corr = 1'b0;
   logic        clr_cnt = 1'b0, clr_fault = 1'b0, irq_ack = 1'b0;
   logic [15:0] sec_thresh = '0;
   logic [3:0]  sec_thresh4 = '0;

   logic [15:0] sec_cnt, ded_cnt, scrub_cnt, scrubfix_cnt;
   logic [7:0]  sec_addr, ded_addr;
   logic [1:0]  health;
   logic        irq;

   logic [3:0]  sec_cnt4, ded_cnt4, scrub_cnt4, scrubfix_cnt4;
   logic [7:0]  sec_addr4, ded_addr4;
   logic [1:0]  health4;
   logic        irq4;

   int n_checks = 0;
   int n_fail   = 0;

   edac_err_monitor_if #(.RAM_LOGDEPTH(8)) dec_if ();

   edac_err_monitor #(.RAM_LOGDEPTH(8), .CNT_WIDTH(16)) u_dut (
      .rClk(rClk), .nGrst(nGrst), .dec(dec_if.slave),
      .scrub_done(scrub_done), .scrub_corr(scrub_corr), .sec_thresh(sec_thresh),
      .clr_cnt(clr_cnt), .clr_fault(clr_fault), .irq_ack(irq_ack),
      .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .scrub_cnt(scrub_cnt),
      .scrubfix_cnt(scrubfix_cnt), .sec_addr(sec_addr), .ded_addr(ded_addr),
      .health(health), .irq(irq)
   );

   edac_err_monitor #(.RAM_LOGDEPTH(8), .CNT_WIDTH(4)) u_dut4 (
      .rClk(rClk), .nGrst(nGrst), .dec(dec_if.slave),
      .scrub_done(scrub_done), .scrub_corr(scrub_corr), .sec_thresh(sec_thresh4),
      .clr_cnt(clr_cnt), .clr_fault(clr_fault), .irq_ack(irq_ack),
      .sec_cnt(sec_cnt4), .ded_cnt(ded_cnt4), .scrub_cnt(scrub_cnt4),
      .scrubfix_cnt(scrubfix_cnt4), .sec_addr(sec_addr4), .ded_addr(ded_addr4),
      .health(health4), .irq(irq4)
   );

   always #5 rClk = ~rClk;

   // f = {dec_valid, correctable, error}; ctl = {scrub_done, scrub_corr, clr_cnt, clr_fault, irq_ack}
   typedef struct {
      logic [2:0] f;
      int         a;
      logic [4:0] ctl;
      int         thr;
      int         x_sec, x_ded, x_scr, x_fix, x_sa, x_da, x_h, x_irq;
   } vec_t;

   vec_t tbl[30];

   task automatic check(input string name, input int idx, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input int e_sec, input int e_ded, input int e_scr,
                            input int e_fix, input int e_sa, input int e_da, input int e_h,
                            input int e_irq);
      check("sec_cnt", idx, int'(sec_cnt), e_sec);
      check("ded_cnt", idx, int'(ded_cnt), e_ded);
      check("scrub_cnt", idx, int'(scrub_cnt), e_scr);
      check("scrubfix_cnt", idx, int'(scrubfix_cnt), e_fix);
      check("sec_addr", idx, int'(sec_addr), e_sa);
      check("ded_addr", idx, int'(ded_addr), e_da);
      check("health", idx, int'(health), e_h);
      check("irq", idx, int'(irq), e_irq);
   endtask

   task automatic drive(input logic [2:0] f, input int a, input logic [4:0] ctl, input int thr);
      {dec_if.dec_valid, dec_if.correctable, dec_if.error} = f;
      dec_if.ram_rA_lat = 8'(a);
      {scrub_done, scrub_corr, clr_cnt, clr_fault, irq_ack} = ctl;
      sec_thresh = 16'(thr);
   endtask

   task automatic step(input logic [2:0] f, input int a, input logic [4:0] ctl, input int thr);
      drive(f, a, ctl, thr);
      @(posedge rClk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{3'b110, 'h10, 5'b00000, 0, 1, 0, 0, 0, 'h10, 0, 0, 0};
      tbl[1]  = '{3'b110, 'h20, 5'b00000, 0, 2, 0, 0, 0, 'h20, 0, 0, 0};
      tbl[2]  = '{3'b110, 'h30, 5'b00000, 0, 3, 0, 0, 0, 'h30, 0, 0, 0};
      tbl[3]  = '{3'b000, 0,    5'b00100, 0, 0, 0, 0, 0, 'h30, 0, 0, 0};
      tbl[4]  = '{3'b110, 'h41, 5'b00000, 2, 1, 0, 0, 0, 'h41, 0, 0, 0};
      tbl[5]  = '{3'b110, 'h42, 5'b00000, 2, 2, 0, 0, 0, 'h42, 0, 1, 1};
      tbl[6]  = '{3'b000, 0,    5'b00001, 2, 2, 0, 0, 0, 'h42, 0, 1, 0};
      tbl[7]  = '{3'b000, 0,    5'b00100, 2, 0, 0, 0, 0, 'h42, 0, 0, 0};
      tbl[8]  = '{3'b101, 'h55, 5'b00000, 0, 0, 1, 0, 0, 'h42, 'h55, 2, 1};
      tbl[9]  = '{3'b101, 'h66, 5'b00000, 0, 0, 2, 0, 0, 'h42, 'h55, 2, 1};
      tbl[10] = '{3'b000, 0,    5'b00001, 0, 0, 2, 0, 0, 'h42, 'h55, 2, 0};
      tbl[11] = '{3'b000, 0,    5'b00010, 0, 0, 2, 0, 0, 'h42, 'h55, 0, 0};
      tbl[12] = '{3'b101, 'h77, 5'b00000, 0, 0, 3, 0, 0, 'h42, 'h77, 2, 1};
      tbl[13] = '{3'b111, 'h88, 5'b00001, 0, 0, 4, 0, 0, 'h42, 'h77, 2, 1};
      tbl[14] = '{3'b011, 'h89, 5'b00000, 0, 0, 4, 0, 0, 'h42, 'h77, 2, 1};
      tbl[15] = '{3'b101, 'h99, 5'b00010, 0, 0, 5, 0, 0, 'h42, 'h99, 2, 1};
      tbl[16] = '{3'b000, 0,    5'b00010, 0, 0, 5, 0, 0, 'h42, 'h99, 0, 1};
      tbl[17] = '{3'b000, 0,    5'b01001, 0, 0, 5, 0, 1, 'h42, 'h99, 0, 0};
      for (int i = 18; i < 23; i++)
         tbl[i] = '{3'b000, 0, 5'b10000, 0, 0, 5, 1, 1, 'h42, 'h99, 0, 0};
      tbl[23] = '{3'b000, 0,    5'b00000, 0, 0, 5, 1, 1, 'h42, 'h99, 0, 0};
      for (int i = 24; i < 29; i++)
         tbl[i] = '{3'b000, 0, 5'b10000, 0, 0, 5, 2, 1, 'h42, 'h99, 0, 0};
      tbl[29] = '{3'b110, 'h5A, 5'b01100, 0, 1, 0, 0, 1, 'h5A, 'h99, 0, 0};

      drive(3'b000, 0, 5'b00000, 0);
      repeat (2) @(posedge rClk);
      #3 nGrst = 1'b1;
      #1 check_all(-1, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 30; i++) begin
         step(tbl[i].f, tbl[i].a, tbl[i].ctl, tbl[i].thr);
         check_all(i, tbl[i].x_sec, tbl[i].x_ded, tbl[i].x_scr, tbl[i].x_fix,
                   tbl[i].x_sa, tbl[i].x_da, tbl[i].x_h, tbl[i].x_irq);
      end

      // Saturation: narrow instance pins at 15, wide instance keeps counting.
      for (int i = 0; i < 20; i++)
         step(3'b110, 'h60 + i, 5'b00000, 0);
      check("sec_cnt4_sat", 100, int'(sec_cnt4), 15);
      check("sec_cnt_wide", 100, int'(sec_cnt), 21);
      check("sec_addr_last", 100, int'(sec_addr), 'h73);
      step(3'b000, 0, 5'b00000, 0);
      check("sec_cnt4_hold", 101, int'(sec_cnt4), 15);
      step(3'b110, 'h2C, 5'b00100, 0);
      check("sec_cnt4_clr_ev", 102, int'(sec_cnt4), 1);
      check("sec_cnt_clr_ev", 102, int'(sec_cnt), 1);

      // Asynchronous reset in the middle of a cycle, with a DED pending.
      step(3'b101, 'hAB, 5'b00000, 0);
      check("ded_addr_pre_rst", 103, int'(ded_addr), 'hAB);
      #2 nGrst = 1'b0;
      #1 check_all(104, 0, 0, 0, 0, 0, 0, 0, 0);
      check("sec_cnt4_rst", 104, int'(sec_cnt4), 0);
      drive(3'b000, 0, 5'b00000, 0);
      @(negedge rClk);
      nGrst = 1'b1;
      step(3'b101, 'hCD, 5'b00000, 0);
      check("ded_addr_post_rst", 105, int'(ded_addr), 'hCD);
      check("health_post_rst", 105, int'(health), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
